// File: rtl/iwdg_wb_driver_pkg.sv
// Shared constants for the IWDG Wishbone driver: watchdog keys, register
// offsets, driver FSM states and error encodings.
package iwdg_pkg;

  typedef enum logic [15:0] {
    KEY_NONE   = 16'h0000,
    KEY_UNLOCK = 16'h5555,
    KEY_RELOAD = 16'hAAAA,
    KEY_START  = 16'hCCCC
  } key_e;

  typedef enum logic [3:0] {
    REG_KR  = 4'h0,
    REG_PR  = 4'h4,
    REG_RLR = 4'h8,
    REG_ST  = 4'hC
  } reg_ofs_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PR,
    ST_WR_RLR,
    ST_WR_UNLOCK,
    ST_CONFIRM,
    ST_WR_START,
    ST_RUN,
    ST_WR_RELOAD,
    ST_WR_RESUME,
    ST_ERROR
  } drv_state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_ACK_TIMEOUT = 2'b01,
    ERR_POLL        = 2'b10
  } err_code_e;

  function automatic logic [31:0] reg_adr(input logic [31:0] base, input reg_ofs_e ofs);
    return base + {28'h0, ofs};
  endfunction

endpackage

// File: rtl/iwdg_wb_driver_if.sv
// Wishbone signal bundle between the IWDG driver (master) and the IWDG slave.
interface iwdg_wb_driver_if #(parameter int DATA_W = 16);
  logic [31:0]       adr_m2s;
  logic [DATA_W-1:0] dat_m2s;
  logic              cyc_m2s;
  logic              stb_m2s;
  logic              we_m2s;
  logic [DATA_W-1:0] dat_s2m;
  logic              ack_s2m;

  modport master (
    output adr_m2s, dat_m2s, cyc_m2s, stb_m2s, we_m2s,
    input  dat_s2m, ack_s2m
  );

  modport slave (
    input  adr_m2s, dat_m2s, cyc_m2s, stb_m2s, we_m2s,
    output dat_s2m, ack_s2m
  );
endinterface

// File: rtl/iwdg_wb_driver_wb_single_xfer.sv
// One-shot Wishbone transfer engine with ack timeout; the read-data port only
// exists when IWDG_DRV_ST_POLL_EN is defined.
module wb_single_xfer #(
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
`ifdef IWDG_DRV_ST_POLL_EN
  output logic [DATA_W-1:0] rdata_o,
`endif
  output logic              done_o,
  output logic              timeout_o,
  iwdg_wb_driver_if.master  bus
);
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;

  logic              active_q, active_d;
  logic [31:0]       adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              we_q, we_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      tmr_q    <= '0;
    end else begin
      active_q <= active_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      tmr_q    <= tmr_d;
    end
  end

  // Requests are only accepted while the bus is idle, so the cycle after an
  // ack or timeout is always a cyc-low gap.
  always_comb begin
    active_d  = active_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    tmr_d     = tmr_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (active_q) begin
      if (bus.ack_s2m) begin
        done_o   = 1'b1;
        active_d = 1'b0;
        we_d     = 1'b0;
      end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
        timeout_o = 1'b1;
        active_d  = 1'b0;
        we_d      = 1'b0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end else if (req_i) begin
      active_d = 1'b1;
      adr_d    = addr_i;
      dat_d    = wdata_i;
      we_d     = we_i;
      tmr_d    = '0;
    end
  end

  assign bus.cyc_m2s = active_q;
  assign bus.stb_m2s = active_q;
  assign bus.adr_m2s = adr_q;
  assign bus.dat_m2s = dat_q;
  assign bus.we_m2s  = we_q;
`ifdef IWDG_DRV_ST_POLL_EN
  assign rdata_o     = bus.dat_s2m;
`endif

endmodule

// File: rtl/iwdg_wb_driver.sv
// Software-less IWDG feeder: configures, starts and periodically refreshes the
// watchdog. IWDG_DRV_ST_POLL_EN selects ST polling instead of a fixed settle wait.
module iwdg_wb_driver
  import iwdg_pkg::*;
#(
  parameter logic [31:0] BASE_ADR       = 32'h0100_0000,
  parameter int          DATA_W         = 16,
  parameter int          REFRESH_PERIOD = 1000,
  parameter int          ACK_TIMEOUT    = 16,
  parameter int          POLL_MAX       = 8
) (
  input  logic              clk_m2s,
  input  logic              rst_m2s,
  input  logic              start,
  input  logic              stop,
  input  logic [2:0]        cfg_pr,
  input  logic [11:0]       cfg_rlr,
  iwdg_wb_driver_if.master  wb,
  output logic              busy,
  output logic              running,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       refresh_cnt
);
  drv_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  pr_q, pr_d;
  logic [11:0] rlr_q, rlr_d;
  logic        err_q, err_d;
  err_code_e   code_q, code_d;
  logic [15:0] rcnt_q, rcnt_d;

  logic              xfer_req, xfer_we, xfer_done, xfer_timeout;
  logic [31:0]       xfer_adr;
  logic [DATA_W-1:0] xfer_dat;
`ifdef IWDG_DRV_ST_POLL_EN
  logic [DATA_W-1:0] xfer_rdata;
`endif

  wb_single_xfer #(.DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) u_xfer (
    .clk_i     (clk_m2s),
    .rst_i     (rst_m2s),
    .req_i     (xfer_req),
    .addr_i    (xfer_adr),
    .wdata_i   (xfer_dat),
    .we_i      (xfer_we),
`ifdef IWDG_DRV_ST_POLL_EN
    .rdata_o   (xfer_rdata),
`endif
    .done_o    (xfer_done),
    .timeout_o (xfer_timeout),
    .bus       (wb)
  );

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      rlr_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      rlr_q   <= rlr_d;
      err_q   <= err_d;
      code_q  <= code_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // stop is only honoured on a transfer completion or in a no-transfer wait
  // state. Waits that end in a KR write launch it directly so the idle gap is
  // exactly the configured count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pr_d     = pr_q;
    rlr_d    = rlr_q;
    err_d    = err_q;
    code_d   = code_q;
    rcnt_d   = rcnt_q;
    xfer_req = 1'b0;
    xfer_we  = 1'b1;
    xfer_adr = reg_adr(BASE_ADR, REG_KR);
    xfer_dat = DATA_W'(KEY_NONE);
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start && !stop) begin
          state_d = ST_WR_PR;
          pr_d    = cfg_pr;
          rlr_d   = cfg_rlr;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end
      end
      ST_WR_PR: begin
        xfer_req = 1'b1;
        xfer_adr = reg_adr(BASE_ADR, REG_PR);
        xfer_dat = DATA_W'(pr_q);
        if (xfer_done) state_d = stop ? ST_IDLE : ST_WR_RLR;
      end
      ST_WR_RLR: begin
        xfer_req = 1'b1;
        xfer_adr = reg_adr(BASE_ADR, REG_RLR);
        xfer_dat = DATA_W'(rlr_q);
        if (xfer_done) state_d = stop ? ST_IDLE : ST_WR_UNLOCK;
      end
      ST_WR_UNLOCK: begin
        xfer_req = 1'b1;
        xfer_dat = DATA_W'(KEY_UNLOCK);
        if (xfer_done) begin
          state_d = stop ? ST_IDLE : ST_CONFIRM;
          cnt_d   = '0;
        end
      end
      ST_CONFIRM: begin
`ifdef IWDG_DRV_ST_POLL_EN
        xfer_req = 1'b1;
        xfer_we  = 1'b0;
        xfer_adr = reg_adr(BASE_ADR, REG_ST);
        if (xfer_done) begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (xfer_rdata[0]) begin
            state_d = ST_WR_START;
          end else if (cnt_q == 32'(POLL_MAX - 1)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            code_d  = ERR_POLL;
          end else begin
            cnt_d = cnt_q + 1;
          end
        end
`else
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 32'(POLL_MAX - 1)) begin
          state_d  = ST_WR_START;
          xfer_req = 1'b1;
          xfer_dat = DATA_W'(KEY_START);
        end else begin
          cnt_d = cnt_q + 1;
        end
`endif
      end
      ST_WR_START: begin
        xfer_req = 1'b1;
        xfer_dat = DATA_W'(KEY_START);
        if (xfer_done) begin
          state_d = stop ? ST_IDLE : ST_RUN;
          cnt_d   = 32'(REFRESH_PERIOD - 1);
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d  = ST_WR_RELOAD;
          xfer_req = 1'b1;
          xfer_dat = DATA_W'(KEY_RELOAD);
        end else begin
          cnt_d = cnt_q - 1;
        end
      end
      ST_WR_RELOAD: begin
        xfer_req = 1'b1;
        xfer_dat = DATA_W'(KEY_RELOAD);
        if (xfer_done) state_d = stop ? ST_IDLE : ST_WR_RESUME;
      end
      ST_WR_RESUME: begin
        xfer_req = 1'b1;
        xfer_dat = DATA_W'(KEY_START);
        if (xfer_done) begin
          rcnt_d  = rcnt_q + 16'd1;
          state_d = stop ? ST_IDLE : ST_RUN;
          cnt_d   = 32'(REFRESH_PERIOD - 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (xfer_timeout) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      code_d  = ERR_ACK_TIMEOUT;
    end
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign running     = (state_q == ST_RUN) || (state_q == ST_WR_RELOAD) || (state_q == ST_WR_RESUME);
  assign err         = err_q;
  assign err_code    = code_q;
  assign refresh_cnt = rcnt_q;

endmodule

// File: tb/tb_iwdg_wb_driver.sv
// Directed bench for iwdg_wb_driver with a registered-ack Wishbone slave model;
// covers both IWDG_DRV_ST_POLL_EN builds.
module tb_iwdg_wb_driver;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          PER   = 20;
  localparam int          TMO   = 16;
  localparam int          POLLS = 8;

  logic        clk_m2s = 1'b0;
  logic        rst_m2s = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  cfg_pr = 3'd0;
  logic [11:0] cfg_rlr = 12'd0;
  logic        busy, running, err;
  logic [1:0]  err_code;
  logic [15:0] refresh_cnt;
  logic        ackEn = 1'b1;
  logic        stReady = 1'b1;

  int total = 0;
  int bad = 0;
  int nXfer = 0;
  int cycleNum = 0;
  int curStart = 0;
  logic cycPrev = 1'b0;
  logic [31:0] logAdr[64];
  logic [15:0] logDat[64];
  logic        logWe[64];
  int          logStart[64];
  int          logEnd[64];

  iwdg_wb_driver_if #(.DATA_W(16)) wb();

  iwdg_wb_driver #(
    .BASE_ADR(BASE), .DATA_W(16), .REFRESH_PERIOD(PER),
    .ACK_TIMEOUT(TMO), .POLL_MAX(POLLS)
  ) dut (
    .clk_m2s(clk_m2s), .rst_m2s(rst_m2s), .start(start), .stop(stop),
    .cfg_pr(cfg_pr), .cfg_rlr(cfg_rlr), .wb(wb), .busy(busy),
    .running(running), .err(err), .err_code(err_code), .refresh_cnt(refresh_cnt)
  );

  always #5 clk_m2s = ~clk_m2s;

  assign wb.dat_s2m = (wb.adr_m2s == BASE + 32'hC) ? {15'h0, stReady} : 16'h0;

  // Slave model: ack one cycle after cyc/stb, and log every acknowledged transfer.
  always @(posedge clk_m2s) begin
    cycleNum <= cycleNum + 1;
    cycPrev <= wb.cyc_m2s;
    if (wb.cyc_m2s && !cycPrev) curStart <= cycleNum;
    wb.ack_s2m <= !rst_m2s && wb.cyc_m2s && wb.stb_m2s && !wb.ack_s2m && ackEn;
    if (wb.cyc_m2s && wb.stb_m2s && wb.ack_s2m && nXfer < 64) begin
      logAdr[nXfer]   <= wb.adr_m2s;
      logDat[nXfer]   <= wb.dat_m2s;
      logWe[nXfer]    <= wb.we_m2s;
      logStart[nXfer] <= curStart;
      logEnd[nXfer]   <= cycleNum;
      nXfer <= nXfer + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] pr, input logic [11:0] rlr);
    @(negedge clk_m2s);
    cfg_pr = pr;
    cfg_rlr = rlr;
    start = 1'b1;
    @(negedge clk_m2s);
    start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_m2s);
  endtask

  task automatic waitXfers(input int n, input int budget, input string tag);
    int i = 0;
    while (nXfer < n && i < budget) begin
      @(negedge clk_m2s);
      i++;
    end
    checkOutput(tag, 32'(nXfer >= n), 32'd1);
  endtask

  task automatic waitBus(input logic anyKey, input logic [15:0] key, input int budget, input string tag);
    int i = 0;
    while (!(wb.cyc_m2s === 1'b1 && (anyKey || wb.dat_m2s === key)) && i < budget) begin
      @(negedge clk_m2s);
      i++;
    end
    checkOutput(tag, 32'(wb.cyc_m2s === 1'b1), 32'd1);
  endtask

  function automatic int idleBetween(input int i, input int j);
    return logStart[j] - logEnd[i] - 1;
  endfunction

  function automatic int stReads(input int from);
    int cnt = 0;
    for (int k = from; k < nXfer; k++) if (logAdr[k] == BASE + 32'hC) cnt++;
    return cnt;
  endfunction

  initial begin
    int b;
    int s;
    int n;

    // Reset values
    repeat (3) @(negedge clk_m2s);
    checkOutput("rst_cyc", 32'(wb.cyc_m2s), 32'd0);
    checkOutput("rst_adr", wb.adr_m2s, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_refresh_cnt", 32'(refresh_cnt), 32'd0);
    rst_m2s = 1'b0;

    // Configuration sequence
    b = nXfer;
`ifdef IWDG_DRV_ST_POLL_EN
    s = b + 4;
`else
    s = b + 3;
`endif
    applyStimulus(3'd3, 12'h123);
    waitXfers(s + 1, 100, "cfg_wait");
    checkOutput("pr_adr", logAdr[b], BASE + 32'h4);
    checkOutput("pr_dat", 32'(logDat[b]), 32'h0003);
    checkOutput("pr_we", 32'(logWe[b]), 32'd1);
    checkOutput("pr_len", 32'(logEnd[b] - logStart[b] + 1), 32'd2);
    checkOutput("rlr_adr", logAdr[b+1], BASE + 32'h8);
    checkOutput("rlr_dat", 32'(logDat[b+1]), 32'h0123);
    checkOutput("pr_rlr_gap", 32'(idleBetween(b, b + 1)), 32'd1);
    checkOutput("unlock_adr", logAdr[b+2], BASE);
    checkOutput("unlock_dat", 32'(logDat[b+2]), 32'h5555);
`ifdef IWDG_DRV_ST_POLL_EN
    checkOutput("st_adr", logAdr[b+3], BASE + 32'hC);
    checkOutput("st_we", 32'(logWe[b+3]), 32'd0);
`else
    checkOutput("confirm_idle", 32'(idleBetween(b + 2, s)), 32'd8);
    checkOutput("no_st_reads", 32'(stReads(b)), 32'd0);
`endif
    checkOutput("start_adr", logAdr[s], BASE);
    checkOutput("start_dat", 32'(logDat[s]), 32'hCCCC);
    checkOutput("running_after_start", 32'(running), 32'd1);
    checkOutput("busy_after_start", 32'(busy), 32'd1);

    // Periodic refresh pairs
    b = nXfer;
    waitXfers(b + 2, 100, "refresh1_wait");
    checkOutput("refresh_cnt_1", 32'(refresh_cnt), 32'd1);
    waitXfers(b + 4, 100, "refresh2_wait");
    checkOutput("refresh_cnt_2", 32'(refresh_cnt), 32'd2);
    checkOutput("ref1_reload", 32'(logDat[b]), 32'hAAAA);
    checkOutput("ref1_resume", 32'(logDat[b+1]), 32'hCCCC);
    checkOutput("ref2_reload", 32'(logDat[b+2]), 32'hAAAA);
    checkOutput("ref2_resume", 32'(logDat[b+3]), 32'hCCCC);
    checkOutput("run_idle_1", 32'(idleBetween(b - 1, b)), 32'd20);
    checkOutput("pair_gap", 32'(idleBetween(b, b + 1)), 32'd1);
    checkOutput("run_idle_2", 32'(idleBetween(b + 1, b + 2)), 32'd20);

    // start while running is ignored
    b = nXfer;
    applyStimulus(3'd1, 12'h055);
    waitXfers(b + 1, 60, "run_start_wait");
    checkOutput("run_start_adr", logAdr[b], BASE);
    checkOutput("run_start_dat", 32'(logDat[b]), 32'hAAAA);
    checkOutput("run_start_running", 32'(running), 32'd1);

    // stop during the reload write
    waitBus(1'b0, 16'hAAAA, 60, "stop_wait_reload");
    stop = 1'b1;
    b = nXfer;
    idleCycles(40);
    checkOutput("stop_xfers", 32'(nXfer), 32'(b + 1));
    checkOutput("stop_last_dat", 32'(logDat[b]), 32'hAAAA);
    checkOutput("stop_running", 32'(running), 32'd0);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    checkOutput("stop_refresh_cnt", 32'(refresh_cnt), 32'd3);

    // start and stop together in IDLE
    b = nXfer;
    applyStimulus(3'd2, 12'h0AA);
    idleCycles(10);
    checkOutput("startstop_xfers", 32'(nXfer), 32'(b));
    checkOutput("startstop_busy", 32'(busy), 32'd0);
    stop = 1'b0;
    idleCycles(2);
    checkOutput("startstop_cyc", 32'(wb.cyc_m2s), 32'd0);

    // Ack timeout on the PR write
    ackEn = 1'b0;
    applyStimulus(3'd5, 12'h7FF);
    waitBus(1'b1, 16'h0, 10, "tmo_wait_cyc");
    checkOutput("tmo_adr", wb.adr_m2s, BASE + 32'h4);
    n = 0;
    while (wb.cyc_m2s === 1'b1 && n < 40) begin
      n++;
      @(negedge clk_m2s);
    end
    checkOutput("tmo_cyc_len", 32'(n), 32'd16);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_err_code", 32'(err_code), 32'd1);
    checkOutput("tmo_busy", 32'(busy), 32'd0);
    idleCycles(5);
    checkOutput("tmo_cyc_stays_low", 32'(wb.cyc_m2s), 32'd0);
    checkOutput("tmo_err_sticky", 32'(err), 32'd1);

    // Restart clears the error
    ackEn = 1'b1;
    b = nXfer;
    applyStimulus(3'd5, 12'h7FF);
    checkOutput("restart_err", 32'(err), 32'd0);
    checkOutput("restart_err_code", 32'(err_code), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    waitXfers(b + 2, 40, "restart_wait");
    checkOutput("restart_pr_dat", 32'(logDat[b]), 32'h0005);
    checkOutput("restart_rlr_dat", 32'(logDat[b+1]), 32'h07FF);

    // Reset in the middle of a transfer
    waitBus(1'b1, 16'h0, 40, "midrst_wait_cyc");
    rst_m2s = 1'b1;
    @(negedge clk_m2s);
    checkOutput("midrst_cyc", 32'(wb.cyc_m2s), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_refresh_cnt", 32'(refresh_cnt), 32'd0);
    rst_m2s = 1'b0;
    idleCycles(2);

`ifdef IWDG_DRV_ST_POLL_EN
    // ST never reports ready
    stReady = 1'b0;
    b = nXfer;
    applyStimulus(3'd0, 12'h010);
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk_m2s);
    end
    checkOutput("poll_err", 32'(err), 32'd1);
    checkOutput("poll_err_code", 32'(err_code), 32'd2);
    checkOutput("poll_reads", 32'(stReads(b)), 32'd8);
    checkOutput("poll_busy", 32'(busy), 32'd0);
`else
    checkOutput("no_st_reads_total", 32'(stReads(0)), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
